// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver with 16x oversampling and a one-byte valid/ready holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits and a parity_err pulse.
`timescale 1ns/1ps
module uart_byte_rx #(
    parameter int CLK_HZ = 12000000,
    parameter int BAUD   = 9600,
    parameter int OSR    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       overrun_clr
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int DIV   = CLK_HZ / (BAUD * OSR);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OSR_W = $clog2(OSR);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [OSR_W-1:0] OSR_LAST = OSR_W'(OSR - 1);
    localparam logic [OSR_W-1:0] OSR_MID  = OSR_W'(OSR / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t            state, state_next;
    logic              rx_meta, rx_s;
    logic [DIV_W-1:0]  div_cnt;
    logic [OSR_W-1:0]  samp_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shreg;
    logic              tick, bit_end;
    logic              samp_clr, shift_en, deliver, stop_bad;
`ifdef UART_RX_PARITY_EN
    logic              par_load, par_bad, par_fail;
`endif

    // Two-flop synchroniser; idles high so reset release never looks like a start edge.
    // NOTE: sequential state is written with non-blocking assignments only, so every flop
    // samples the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Divider is parked at zero while idle so the first tick lands DIV cycles after the start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  div_cnt <= '0;
        else if (state == IDLE)      div_cnt <= '0;
        else if (div_cnt == DIV_LAST) div_cnt <= '0;
        else                         div_cnt <= div_cnt + 1'b1;
    end

    assign tick    = (state != IDLE) && (div_cnt == DIV_LAST);
    assign bit_end = tick && (samp_cnt == OSR_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every signal driven here gets a default first, so no path through the case
    // statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        samp_clr   = 1'b0;
        shift_en   = 1'b0;
        deliver    = 1'b0;
        stop_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_load   = 1'b0;
        par_fail   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    samp_clr   = 1'b1;
                end
            end
            START: begin
                if (tick && (samp_cnt == OSR_MID)) begin
                    samp_clr   = 1'b1;
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_en = 1'b1;
                    samp_clr = 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    par_load   = 1'b1;
                    samp_clr   = 1'b1;
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    samp_clr   = 1'b1;
                    state_next = IDLE;
`ifdef UART_RX_PARITY_EN
                    par_fail   = par_bad;
                    deliver    = rx_s && !par_bad;
`else
                    deliver    = rx_s;
`endif
                    stop_bad   = !rx_s;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            if (state == IDLE || samp_clr) samp_cnt <= '0;
            else if (tick)                 samp_cnt <= samp_cnt + 1'b1;

            if (state != DATA)   bit_idx <= '0;
            else if (shift_en)   bit_idx <= bit_idx + 1'b1;

            // LSB arrives first, so shift right and insert at the top.
            if (shift_en) shreg <= {rx_s, shreg[7:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: data bits plus parity bit must hold an even number of ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        par_bad <= 1'b0;
        else if (par_load) par_bad <= ^{shreg, rx_s};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) parity_err <= 1'b0;
        else        parity_err <= par_fail;
    end
`endif

    // Holding register: a delivery lands if the slot is empty or being drained this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            if (deliver && (!rx_valid || rx_ready)) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (deliver && rx_valid && !rx_ready) overrun <= 1'b1;
            else if (overrun_clr)                 overrun <= 1'b0;
        end
    end

endmodule
